el2_dec_gpr_mp: RTL and testbench



---
 rtl/el2_dec_gpr_mp.sv | 133 +++++++++++++
 tb/tb_el2_dec_gpr_mp.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/el2_dec_gpr_mp.sv
// Multi-port integer register file with write priority, collision status and pending scoreboard.
// Optional same-cycle write forwarding on read ports: define GPR_BYPASS_EN.
module el2_dec_gpr_mp #(
    parameter int DW       = 32,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 3,
    parameter int ZERO_REG = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NRD*$clog2(NREG)-1:0]  raddr,
    output logic [NRD*DW-1:0]            rd,
    output logic [NRD-1:0]               rbusy,
    input  logic [NWR-1:0]               wen,
    input  logic [NWR*$clog2(NREG)-1:0]  waddr,
    input  logic [NWR*DW-1:0]            wd,
    input  logic                         iss_vld,
    input  logic [$clog2(NREG)-1:0]      iss_addr,
    input  logic                         coll_clr,
    output logic                         coll_pulse,
    output logic                         coll_sticky,
    output logic [$clog2(NREG):0]        pend_cnt,
    input  logic                         scan_mode
);
    localparam int   AW = $clog2(NREG);
    localparam logic ZR = (ZERO_REG != 0);

    logic [DW-1:0]   rf_q [NREG];
    logic [DW-1:0]   wdat [NREG];
    logic [NREG-1:0] we;
    logic [NREG-1:0] pend_q, pend_d;
    logic [NWR-1:0]  wvld;
    logic            coll;
    logic            coll_pulse_q, coll_sticky_q, coll_sticky_d;
    logic [AW:0]     pend_cnt_q, pend_cnt_d;

    // No clock-gating cells are instantiated here; per-register enables gate the flops.
    logic unused_scan;
    assign unused_scan = scan_mode;

    always_comb begin
        wvld = '0;
        for (int j = 0; j < NWR; j++)
            wvld[j] = wen[j] && !(ZR && waddr[j*AW +: AW] == '0);
    end

    // Descending scan so the lowest-index port is the last to assign and wins.
    always_comb begin
        we = '0;
        for (int r = 0; r < NREG; r++) begin
            wdat[r] = '0;
            for (int j = NWR - 1; j >= 0; j--) begin
                if (wvld[j] && waddr[j*AW +: AW] == AW'(r)) begin
                    we[r]   = 1'b1;
                    wdat[r] = wd[j*DW +: DW];
                end
            end
        end
    end

    always_comb begin
        coll = 1'b0;
        for (int j = 0; j < NWR; j++)
            for (int k = j + 1; k < NWR; k++)
                if (wvld[j] && wvld[k] &&
                    waddr[j*AW +: AW] == waddr[k*AW +: AW])
                    coll = 1'b1;
    end

    always_comb begin
        pend_d     = '0;
        pend_cnt_d = '0;
        for (int r = 0; r < NREG; r++) begin
            pend_d[r] = (iss_vld && iss_addr == AW'(r) && !(ZR && r == 0))
                      || (pend_q[r] && !we[r]);
            pend_cnt_d = pend_cnt_d + {{AW{1'b0}}, pend_d[r]};
        end
    end

    assign coll_sticky_d = coll || (coll_sticky_q && !coll_clr);

    for (genvar r = 0; r < NREG; r++) begin : g_rf
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                rf_q[r] <= '0;
            else if (we[r])
                rf_q[r] <= wdat[r];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q        <= '0;
            pend_cnt_q    <= '0;
            coll_pulse_q  <= 1'b0;
            coll_sticky_q <= 1'b0;
        end else begin
            pend_q        <= pend_d;
            pend_cnt_q    <= pend_cnt_d;
            coll_pulse_q  <= coll;
            coll_sticky_q <= coll_sticky_d;
        end
    end

    always_comb begin
        rd    = '0;
        rbusy = '0;
        for (int i = 0; i < NRD; i++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] rdata;
            logic          busy;
            a     = raddr[i*AW +: AW];
            rdata = (ZR && a == '0) ? '0 : rf_q[a];
            busy  = pend_q[a];
`ifdef GPR_BYPASS_EN
            for (int j = NWR - 1; j >= 0; j--) begin
                if (wvld[j] && waddr[j*AW +: AW] == a) begin
                    rdata = wd[j*DW +: DW];
                    busy  = 1'b0;
                end
            end
`endif
            rd[i*DW +: DW] = rdata;
            rbusy[i]       = busy;
        end
    end

    assign coll_pulse  = coll_pulse_q;
    assign coll_sticky = coll_sticky_q;
    assign pend_cnt    = pend_cnt_q;

endmodule

// File: tb/tb_el2_dec_gpr_mp.sv
// Randomized and directed bench for el2_dec_gpr_mp against an array-based reference model.
// The model honours GPR_BYPASS_EN when the bench is built with it.
module tb_el2_dec_gpr_mp;
    localparam int DW = 32, NREG = 32, NRD = 2, NWR = 3, AW = 5;

    logic                clk = 0, rst = 1;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*DW-1:0]   rd;
    logic [NRD-1:0]      rbusy;
    logic [NWR-1:0]      wen;
    logic [NWR*AW-1:0]   waddr;
    logic [NWR*DW-1:0]   wd;
    logic                iss_vld;
    logic [AW-1:0]       iss_addr;
    logic                coll_clr;
    logic                coll_pulse, coll_sticky;
    logic [AW:0]         pend_cnt;
    logic                scan_mode;

    el2_dec_gpr_mp #(.DW(DW), .NREG(NREG), .NRD(NRD), .NWR(NWR), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .raddr(raddr), .rd(rd), .rbusy(rbusy),
        .wen(wen), .waddr(waddr), .wd(wd), .iss_vld(iss_vld),
        .iss_addr(iss_addr), .coll_clr(coll_clr), .coll_pulse(coll_pulse),
        .coll_sticky(coll_sticky), .pend_cnt(pend_cnt), .scan_mode(scan_mode)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    logic [31:0] m_rf [NREG];
    bit          m_pend [NREG];
    bit          m_pulse, m_sticky;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int r = 0; r < NREG; r++) begin
            m_rf[r]   = 0;
            m_pend[r] = 0;
        end
        m_pulse  = 0;
        m_sticky = 0;
    endtask

    task automatic idle();
        wen      = '0;
        waddr    = '0;
        wd       = '0;
        iss_vld  = 0;
        iss_addr = '0;
        coll_clr = 0;
    endtask

    task automatic setw(input int j, input int a, input logic [31:0] d);
        wen[j]          = 1'b1;
        waddr[j*AW+:AW] = AW'(a);
        wd[j*DW+:DW]    = d;
    endtask

    task automatic setr(input int i, input int a);
        raddr[i*AW+:AW] = AW'(a);
    endtask

    task automatic compare_all();
        int cnt;
        for (int i = 0; i < NRD; i++) begin
            int a;
            logic [31:0] er;
            bit eb;
            a  = int'(raddr[i*AW+:AW]);
            er = (a == 0) ? 32'h0 : m_rf[a];
            eb = m_pend[a];
`ifdef GPR_BYPASS_EN
            for (int j = 0; j < NWR; j++) begin
                if (wen[j] && a != 0 && int'(waddr[j*AW+:AW]) == a) begin
                    er = wd[j*DW+:DW];
                    eb = 0;
                    break;
                end
            end
`endif
            chk($sformatf("rd%0d", i), 64'(rd[i*DW+:DW]), 64'(er));
            chk($sformatf("rbusy%0d", i), 64'(rbusy[i]), 64'(eb));
        end
        cnt = 0;
        for (int r = 0; r < NREG; r++) cnt += int'(m_pend[r]);
        chk("coll_pulse", 64'(coll_pulse), 64'(m_pulse));
        chk("coll_sticky", 64'(coll_sticky), 64'(m_sticky));
        chk("pend_cnt", 64'(pend_cnt), 64'(cnt));
    endtask

    // Inputs are driven at the falling edge; check, then advance the model over one rising edge.
    task automatic step();
        logic [31:0] nrf [NREG];
        bit npend [NREG];
        bit claimed [NREG];
        bit hit;
        #1 compare_all();
        hit = 0;
        for (int r = 0; r < NREG; r++) begin
            nrf[r]     = m_rf[r];
            npend[r]   = m_pend[r];
            claimed[r] = 0;
        end
        for (int j = 0; j < NWR; j++) begin
            int a;
            a = int'(waddr[j*AW+:AW]);
            if (wen[j] && a != 0) begin
                if (claimed[a]) hit = 1;
                else begin
                    nrf[a]     = wd[j*DW+:DW];
                    claimed[a] = 1;
                end
                npend[a] = 0;
            end
        end
        if (iss_vld && iss_addr != 0) npend[iss_addr] = 1;
        @(posedge clk);
        for (int r = 0; r < NREG; r++) begin
            m_rf[r]   = nrf[r];
            m_pend[r] = npend[r];
        end
        m_sticky = hit || (m_sticky && !coll_clr);
        m_pulse  = hit;
        @(negedge clk);
    endtask

    initial begin
        scan_mode = 0;
        raddr     = '0;
        idle();
        m_reset();
        #1 compare_all();
        @(negedge clk);
        rst = 0;

        // write then read
        setw(1, 7, 32'h12345678);
        setr(0, 7);
        step();
        idle();
        #1 chk("wr_rd", 64'(rd[31:0]), 64'h12345678);
        step();

        // three-way collision on reg9
        setw(0, 9, 32'hA);
        setw(1, 9, 32'hB);
        setw(2, 9, 32'hC);
        step();
        idle();
        setr(0, 9);
        #1 chk("coll_val", 64'(rd[31:0]), 64'hA);
        chk("coll_pulse1", 64'(coll_pulse), 64'h1);
        step();
        step();
        coll_clr = 1;
        step();
        idle();
        step();

        // zero register
        setw(0, 0, 32'hFFFFFFFF);
        setw(1, 0, 32'h55555555);
        iss_vld  = 1;
        iss_addr = 0;
        setr(0, 0);
        step();
        idle();
        #1 chk("zero_coll", 64'(coll_pulse), 64'h0);
        step();

        // scoreboard
        iss_vld  = 1;
        iss_addr = 3;
        step();
        idle();
        setr(0, 3);
        #1 chk("sb_busy", 64'(rbusy[0]), 64'h1);
        chk("sb_cnt1", 64'(pend_cnt), 64'h1);
        step();
        setw(0, 3, 32'h33);
        iss_vld  = 1;
        iss_addr = 3;
        step();
        idle();
        step();
        setw(0, 3, 32'h34);
        step();
        idle();
        #1 chk("sb_cnt0", 64'(pend_cnt), 64'h0);
        step();

        // full scoreboard
        for (int r = 1; r < NREG; r++) begin
            iss_vld  = 1;
            iss_addr = AW'(r);
            step();
        end
        idle();
        #1 chk("full_cnt", 64'(pend_cnt), 64'd31);
        for (int c = 0; c < 11; c++) begin
            idle();
            for (int j = 0; j < NWR; j++)
                if (c*3 + j + 1 < NREG) setw(j, c*3 + j + 1, $urandom);
            step();
        end
        idle();
        #1 chk("drain_cnt", 64'(pend_cnt), 64'd0);
        step();

        // random traffic, addresses often narrowed to provoke collisions
        for (int n = 0; n < 400; n++) begin
            bit narrow;
            idle();
            narrow = ($urandom_range(0, 1) == 1);
            for (int j = 0; j < NWR; j++)
                if ($urandom_range(0, 2) != 0)
                    setw(j, narrow ? $urandom_range(0, 3) : $urandom_range(0, 31), $urandom);
            for (int i = 0; i < NRD; i++) setr(i, $urandom_range(0, 31));
            iss_vld  = ($urandom_range(0, 1) == 1);
            iss_addr = AW'($urandom_range(0, 31));
            coll_clr = ($urandom_range(0, 7) == 0);
            step();
        end

        // asynchronous reset mid-run
        idle();
        setw(0, 5, 32'hDEADBEEF);
        iss_vld  = 1;
        iss_addr = 6;
        step();
        idle();
        setr(0, 5);
        #1 chk("pre_rst", 64'(rd[31:0]), 64'hDEADBEEF);
        #1 rst = 1;
        #1 chk("rst_rd", 64'(rd[31:0]), 64'h0);
        chk("rst_cnt", 64'(pend_cnt), 64'h0);
        m_reset();
        compare_all();
        #1 rst = 0;
        @(negedge clk);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
